// File: rtl/pipelined_add_accumulator_pkg.sv
// Shared widths, FSM encodings and a saturating-increment helper for the split-half accumulator.
package pipelined_add_accumulator_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_CNT_W = 8;

   localparam logic [1:0] ST_ACCEPT = 2'd0;
   localparam logic [1:0] ST_ADD_HI = 2'd1;
   localparam logic [1:0] ST_HOLD   = 2'd2;

   function automatic logic [DEF_CNT_W-1:0] sat_inc(input logic [DEF_CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/pipelined_add_accumulator_if.sv
// Operand stream in, frame result out; master is the upstream/downstream side, slave is the accumulator.
interface pipelined_add_accumulator_if #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_ovf;
   logic [CNT_W-1:0] out_count;

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, out_count
   );

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, out_count
   );
endinterface

// File: rtl/pipelined_add_accumulator_half_width_adder.sv
// Combinational W-bit a+b+cin with carry out; shared by both accumulation phases.
module half_width_adder #(
   parameter int W = 16
) (
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         cin_i,
   output logic [W-1:0] sum_o,
   output logic         cout_o
);
   logic [W:0] full;

   assign full   = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
   assign sum_o  = full[W-1:0];
   assign cout_o = full[W];
endmodule

// File: rtl/pipelined_add_accumulator.sv
// Frame accumulator: each operand takes two cycles (low half, then high half + carry); result held until out_ready.
// Last beat reaches HOLD one cycle after its handshake; in_ready is low in ADD_HI and HOLD.
module pipelined_add_accumulator
   import pipelined_add_accumulator_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = DEF_CNT_W
) (
   input logic                         clk,
   input logic                         rst,
   pipelined_add_accumulator_if.slave  bus
);
   localparam int HALF = WIDTH / 2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic             carry_q, carry_d;
   logic [HALF-1:0]  data_hi_q, data_hi_d;
   logic             last_q, last_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [HALF-1:0]  add_a, add_b, add_sum;
   logic             add_cin, add_cout;
   logic             in_accept;

   // One adder serves both phases; the state selects which halves feed it.
   assign add_a   = (state_q == ST_ACCEPT) ? acc_q[HALF-1:0]        : acc_q[WIDTH-1:HALF];
   assign add_b   = (state_q == ST_ACCEPT) ? bus.in_data[HALF-1:0]  : data_hi_q;
   assign add_cin = (state_q == ST_ACCEPT) ? 1'b0                   : carry_q;

   half_width_adder #(.W(HALF)) u_adder (
      .a_i   (add_a),
      .b_i   (add_b),
      .cin_i (add_cin),
      .sum_o (add_sum),
      .cout_o(add_cout)
   );

   assign in_accept = (state_q == ST_ACCEPT) && bus.in_valid;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      carry_d   = carry_q;
      data_hi_d = data_hi_q;
      last_d    = last_q;
      ovf_d     = ovf_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_ACCEPT: begin
            if (in_accept) begin
               acc_d[HALF-1:0] = add_sum;
               carry_d         = add_cout;
               data_hi_d       = bus.in_data[WIDTH-1:HALF];
               last_d          = bus.in_last;
               state_d         = ST_ADD_HI;
            end
         end
         ST_ADD_HI: begin
            acc_d[WIDTH-1:HALF] = add_sum;
            ovf_d               = ovf_q | add_cout;
            cnt_d               = sat_inc(cnt_q);
            state_d             = last_q ? ST_HOLD : ST_ACCEPT;
         end
         ST_HOLD: begin
            if (bus.out_ready) begin
               acc_d   = '0;
               ovf_d   = 1'b0;
               cnt_d   = '0;
               state_d = ST_ACCEPT;
            end
         end
         default: state_d = ST_ACCEPT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_ACCEPT;
         acc_q     <= '0;
         carry_q   <= 1'b0;
         data_hi_q <= '0;
         last_q    <= 1'b0;
         ovf_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         carry_q   <= carry_d;
         data_hi_q <= data_hi_d;
         last_q    <= last_d;
         ovf_q     <= ovf_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.in_ready  = (state_q == ST_ACCEPT);
   assign bus.out_valid = (state_q == ST_HOLD);
   assign bus.out_sum   = acc_q;
   assign bus.out_ovf   = ovf_q;
   assign bus.out_count = cnt_q;
endmodule

// File: tb/tb_pipelined_add_accumulator.sv
// Directed frames with hand-computed results pushed to a scoreboard; a monitor checks each accepted result.
module tb_pipelined_add_accumulator;

   typedef struct packed {
      logic [31:0] sum;
      logic        ovf;
      logic [7:0]  count;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   pipelined_add_accumulator_if #(.WIDTH(32), .CNT_W(8)) bus_if ();

   pipelined_add_accumulator #(.WIDTH(32), .CNT_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus_if)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Drives one beat just after a rising edge and holds it until the handshake edge.
   task automatic send_beat(input logic [31:0] data, input logic last);
      bit done = 0;
      @(posedge clk);
      #1;
      bus_if.in_valid = 1'b1;
      bus_if.in_data  = data;
      bus_if.in_last  = last;
      for (int i = 0; i < 20 && !done; i++) begin
         @(negedge clk);
         if (bus_if.in_ready === 1'b1) begin
            @(posedge clk);
            #1;
            done = 1;
         end
      end
      bus_if.in_valid = 1'b0;
      if (!done) chk("beat_accept_timeout", 32'd0, 32'd1);
   endtask

   // Monitor: every result handshake pops one expected frame.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_result", 32'd1, 32'd0);
            end else begin
               e = sb_q.pop_front();
               chk("out_sum",   bus_if.out_sum,           e.sum);
               chk("out_ovf",   {31'd0, bus_if.out_ovf},  {31'd0, e.ovf});
               chk("out_count", {24'd0, bus_if.out_count}, {24'd0, e.count});
            end
         end
      end
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog timeout");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      bit seen;
      rst              = 1'b1;
      bus_if.in_valid  = 1'b0;
      bus_if.in_data   = '0;
      bus_if.in_last   = 1'b0;
      bus_if.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, bus_if.in_ready},  32'd1);
      chk("rst_out_sum",   bus_if.out_sum,            32'd0);
      chk("rst_out_count", {24'd0, bus_if.out_count}, 32'd0);
      chk("rst_out_ovf",   {31'd0, bus_if.out_ovf},   32'd0);

      // Basic frame; last beat driven after edge N is sampled at N+1, result visible after N+2.
      bus_if.out_ready = 1'b0;
      sb_q.push_back('{sum: 32'd63, ovf: 1'b0, count: 8'd2});
      send_beat(32'd30, 1'b0);
      send_beat(32'd33, 1'b1);
      @(negedge clk);
      chk("latency_not_yet", {31'd0, bus_if.out_valid}, 32'd0);
      @(negedge clk);
      chk("latency_valid", {31'd0, bus_if.out_valid}, 32'd1);
      @(posedge clk);
      #1;
      bus_if.out_ready = 1'b1;

      // Carry from low half into high half.
      sb_q.push_back('{sum: 32'h0001_0000, ovf: 1'b0, count: 8'd2});
      send_beat(32'h0000_FFFF, 1'b0);
      send_beat(32'h0000_0001, 1'b1);

      // Wrap sets ovf, next frame starts clean.
      sb_q.push_back('{sum: 32'h0000_0001, ovf: 1'b1, count: 8'd2});
      send_beat(32'hFFFF_FFFF, 1'b0);
      send_beat(32'h0000_0002, 1'b1);
      sb_q.push_back('{sum: 32'd25, ovf: 1'b0, count: 8'd1});
      send_beat(32'd25, 1'b1);

      // Backpressure: result held for 5 cycles.
      sb_q.push_back('{sum: 32'd600, ovf: 1'b0, count: 8'd3});
      send_beat(32'd100, 1'b0);
      send_beat(32'd200, 1'b0);
      bus_if.out_ready = 1'b0;
      send_beat(32'd300, 1'b1);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         if (bus_if.out_valid === 1'b1) seen = 1;
      end
      if (!seen) chk("hold_valid_timeout", 32'd0, 32'd1);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         chk("hold_out_valid", {31'd0, bus_if.out_valid}, 32'd1);
         chk("hold_in_ready",  {31'd0, bus_if.in_ready},  32'd0);
         chk("hold_out_sum",   bus_if.out_sum,            32'd600);
         chk("hold_out_count", {24'd0, bus_if.out_count}, 32'd3);
      end
      @(posedge clk);
      #1;
      bus_if.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("release_in_ready",  {31'd0, bus_if.in_ready},  32'd1);
      chk("release_acc_clear", bus_if.out_sum,            32'd0);
      chk("release_cnt_clear", {24'd0, bus_if.out_count}, 32'd0);

      // Reset while in ADD_HI abandons the frame.
      send_beat(32'h1234_5678, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_in_ready",  {31'd0, bus_if.in_ready},  32'd1);
      chk("midrst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
      chk("midrst_acc",       bus_if.out_sum,            32'd0);
      sb_q.push_back('{sum: 32'd7, ovf: 1'b0, count: 8'd1});
      send_beat(32'd7, 1'b1);

      // Beat counter saturates at 255 while the sum keeps counting.
      sb_q.push_back('{sum: 32'd300, ovf: 1'b0, count: 8'd255});
      for (int i = 0; i < 300; i++) send_beat(32'd1, i == 299);

      seen = 0;
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (sb_q.size() == 0) seen = 1;
      end
      if (!seen) chk("drain_timeout", sb_q.size(), 32'd0);
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
